imm_issue_ctrl: RTL
===================

# imm_issue_ctrl

Decode-stage immediate issue controller for the pipelined RV32I core. It accepts fetched instructions over a valid/ready handshake and decodes the opcode into the immediate-select code. It drives an internal `imm_extend` instance and buffers the instruction, select code and extended immediate in a small FIFO for the execute stage. It also serialises CSR instructions by holding issue until the CSR write commits.

## Interface
Parameters:
- `DEPTH`, default 2: FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `in_valid_i`  in  1  fetch has an instruction.
- `in_ready_o`  out  1  controller can accept; equals `!full`.
- `instr_i`  in  32  fetched instruction.
- `out_valid_o`  out  1  head entry is issuable.
- `out_ready_i`  in  1  execute stage accepts the head.
- `instr_o`  out  32  head instruction.
- `imm_src_o`  out  3  head immediate-select code.
- `imm_ext_o`  out  32  head extended immediate.
- `illegal_o`  out  1  head opcode is unrecognised.
- `flush_i`  in  1  synchronous pipeline flush.
- `csr_commit_i`  in  1  CSR write has committed in writeback.

## Operation
Decode happens at enqueue, and the result is stored with the entry. Mapping from `instr_i[6:0]`:
- 0000011, 0010011, 1100111 → `I_EXT`
- 0100011 → `S_EXT`
- 1100011 → `B_EXT`
- 1101111 → `J_EXT`
- 0110111, 0010111 → `U_EXT`
- 1110011:
  - funct3[2]=1 → `CSR_EXT`
  - funct3 001/010/011 → `I_EXT`
  - funct3 000 → `IMM_NONE`
- 0110011, 0001111 → `IMM_NONE`, legal
- Any other opcode → `IMM_NONE`, and `illegal_o`=1 for that entry.

`IMM_NONE` produces `imm_ext_o` = 0, via the `imm_extend` default arm.

Handshakes:
- Enqueue when `in_valid_i && in_ready_o && !flush_i`.
- Dequeue when `out_valid_o && out_ready_i && !flush_i`.
- Enqueue and dequeue may occur in the same cycle; the count is then unchanged.
- When full, `in_ready_o`=0. There is no bypass, and a write to a full FIFO never occurs.

CSR classification: an entry is a CSR entry when the opcode is 1110011 and funct3 ≠ 000.

State machine with two states, RUN and CSR_WAIT:
- RUN:
  - `out_valid_o` = `!empty`.
  - A dequeue of a CSR entry moves the FSM to CSR_WAIT.
- CSR_WAIT:
  - `out_valid_o` is forced to 0.
  - The FIFO may still fill from fetch.
  - `csr_commit_i`=1 moves the FSM to RUN at the next edge.
  - `flush_i` also moves the FSM to RUN.
- `csr_commit_i` received while in RUN is ignored.

Flush:
- Clears count and pointers, and moves the FSM to RUN.
- Flush has priority over a simultaneous enqueue, dequeue or commit.
- The dropped instructions are not issued.

Pointers are `$clog2(DEPTH)` bits and wrap naturally. The count is `$clog2(DEPTH)+1` bits.

## Timing
Reset values:
- `in_ready_o`=1
- `out_valid_o`=0
- `instr_o`=0
- `imm_ext_o`=0
- `imm_src_o`=0
- `illegal_o`=0
- FSM in RUN; all storage cleared.

Reset asserted mid-operation discards all entries immediately, asynchronously.

Latency and throughput:
- An instruction enqueued at edge N is visible on the outputs, with `out_valid_o`=1, after edge N (registered, 1-cycle latency).
- Sustained throughput is 1 per cycle when `out_ready_i`=1.

Output rules:
- All outputs are pure functions of registered state; no combinational input-to-output path.
- While `out_valid_o`=1 and `out_ready_i`=0, the head outputs hold stable.

CSR stall:
- A CSR entry dequeued at edge N gives `out_valid_o`=0 from N onward.
- With `csr_commit_i` high in cycle M, `out_valid_o` may be 1 again after edge M.

## Structure
- Immediate-select encodings (`I_EXT`…`CSR_EXT`) come from the shared control macros. `IMM_NONE` (3'b111) and the RV32I opcode constants are added there.
- The FSM state enum goes in the shared core package.
- One sub-module: `imm_extend`, instantiated on the enqueue path, with `instr_i[31:7]` in and the decoded select in.
- FIFO storage and pointer logic stay inline.

## Test plan
- Reset, then enqueue 0xFFF00093 (addi x1,x0,-1), with `out_ready_i`=1 → one cycle later `out_valid_o`=1, `imm_src_o`=`I_EXT`, `imm_ext_o`=0xFFFFFFFF.
- Enqueue 0x12345037 (lui) then 0xFE000EE3 (beq −4) back-to-back → `imm_ext_o` 0x12345000 then 0xFFFFFFFC, on consecutive cycles.
- Hold `out_ready_i`=0 and offer 3 instructions → 2 accepted and `in_ready_o`=0. Release → issue in order, with `in_ready_o`=1 after the first dequeue.
- Issue 0x3002D073 (csrrwi, zimm 5) followed by an addi:
  - `imm_ext_o`=0x5 on the CSR entry.
  - `out_valid_o` stays 0 for 4 cycles.
  - Pulse `csr_commit_i` → the addi issues on the next cycle.
- With 2 entries queued, assert `flush_i` together with `in_valid_i` → next cycle empty, `out_valid_o`=0, and the new instruction is dropped.
- Enqueue opcode 0x0000007F → `illegal_o`=1, `imm_src_o`=`IMM_NONE`, `imm_ext_o`=0. Then assert `reset_i` asynchronously mid-cycle → all outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/imm_issue_ctrl_pkg.sv
// rtl/imm_issue_ctrl_pkg.sv - shared encodings, entry types and opcode decode for the immediate issue controller
package imm_issue_ctrl_pkg;

   // Immediate-select encodings shared with the extend unit
   localparam logic [2:0] I_EXT    = 3'b000;
   localparam logic [2:0] S_EXT    = 3'b001;
   localparam logic [2:0] B_EXT    = 3'b010;
   localparam logic [2:0] J_EXT    = 3'b011;
   localparam logic [2:0] U_EXT    = 3'b100;
   localparam logic [2:0] CSR_EXT  = 3'b101;
   localparam logic [2:0] IMM_NONE = 3'b111;

   // RV32I major opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   // Issue FSM states
   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_CSR_WAIT = 1'b1;

   typedef struct packed {
      logic [2:0] imm_src;
      logic       illegal;
      logic       is_csr;
   } decode_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [2:0]  imm_src;
      logic [31:0] imm_ext;
      logic        illegal;
      logic        is_csr;
   } entry_t;

   // SYSTEM with funct3 == 000 (ecall/ebreak/mret) carries no immediate and does not serialise
   function automatic decode_t decode_op(input logic [6:0] opcode, input logic [2:0] funct3);
      decode_t d;
      d.imm_src = IMM_NONE;
      d.illegal = 1'b0;
      d.is_csr  = 1'b0;
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR: d.imm_src = I_EXT;
         OP_STORE:                 d.imm_src = S_EXT;
         OP_BRANCH:                d.imm_src = B_EXT;
         OP_JAL:                   d.imm_src = J_EXT;
         OP_LUI, OP_AUIPC:         d.imm_src = U_EXT;
         OP_SYSTEM: begin
            d.is_csr = (funct3 != 3'b000);
            if (funct3[2])
               d.imm_src = CSR_EXT;
            else if (funct3 != 3'b000)
               d.imm_src = I_EXT;
            else
               d.imm_src = IMM_NONE;
         end
         OP_REG, OP_FENCE:         d.imm_src = IMM_NONE;
         default:                  d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/imm_issue_ctrl_imm_extend.sv
// rtl/imm_issue_ctrl_imm_extend.sv - RV32I immediate extraction and sign extension
module imm_extend
   import imm_issue_ctrl_pkg::*;
(
   input  logic [31:7] instr_i,
   input  logic [2:0]  imm_src_i,
   output logic [31:0] imm_ext_o
);

   // Reassemble the scattered immediate fields for the selected format
   always_comb begin
      imm_ext_o = 32'd0;
      case (imm_src_i)
         I_EXT:   imm_ext_o = {{20{instr_i[31]}}, instr_i[31:20]};
         S_EXT:   imm_ext_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         B_EXT:   imm_ext_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                               instr_i[30:25], instr_i[11:8], 1'b0};
         J_EXT:   imm_ext_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                               instr_i[20], instr_i[30:21], 1'b0};
         U_EXT:   imm_ext_o = {instr_i[31:12], 12'd0};
         CSR_EXT: imm_ext_o = {27'd0, instr_i[19:15]};
         default: imm_ext_o = 32'd0;
      endcase
   end

endmodule

// File: rtl/imm_issue_ctrl.sv
// rtl/imm_issue_ctrl.sv - decode-stage immediate issue FIFO with CSR serialisation
module imm_issue_ctrl
   import imm_issue_ctrl_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] instr_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] instr_o,
   output logic [2:0]  imm_src_o,
   output logic [31:0] imm_ext_o,
   output logic        illegal_o,
   input  logic        flush_i,
   input  logic        csr_commit_i
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [0:0]    state_q, state_d;
   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];

   decode_t       dec;
   logic [31:0]   ext_w;
   entry_t        head;
   logic          full, empty, enq, deq;

   assign dec = decode_op(instr_i[6:0], instr_i[14:12]);

   imm_extend u_imm_extend (
      .instr_i   (instr_i[31:7]),
      .imm_src_i (dec.imm_src),
      .imm_ext_o (ext_w)
   );

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   assign in_ready_o  = !full;
   assign out_valid_o = (state_q == ST_RUN) && !empty;
   assign instr_o     = head.instr;
   assign imm_src_o   = head.imm_src;
   assign imm_ext_o   = head.imm_ext;
   assign illegal_o   = head.illegal;

   assign enq = in_valid_i && !full && !flush_i;
   assign deq = out_valid_o && out_ready_i && !flush_i;

   // Next-state: storage write, pointer/count update and CSR stall FSM; flush overrides all
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      state_d  = state_q;

      if (enq) begin
         mem_d[wr_ptr_q] = '{instr:   instr_i,
                             imm_src: dec.imm_src,
                             imm_ext: ext_w,
                             illegal: dec.illegal,
                             is_csr:  dec.is_csr};
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (deq)
         rd_ptr_d = rd_ptr_q + PW'(1);

      if (enq && !deq)
         count_d = count_q + CW'(1);
      else if (!enq && deq)
         count_d = count_q - CW'(1);

      case (state_q)
         ST_RUN:      if (deq && head.is_csr) state_d = ST_CSR_WAIT;
         ST_CSR_WAIT: if (csr_commit_i)       state_d = ST_RUN;
         default:                             state_d = ST_RUN;
      endcase

      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         state_d  = ST_RUN;
      end
   end

   // State registers; reset also wipes storage so head outputs read zero
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= ST_RUN;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= mem_d[i];
      end
   end

endmodule
